pipe_hazard_ctl: RTL and testbench

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

---
 rtl/pipe_hazard_ctl_if.sv | 30 +++
 rtl/pipe_hazard_ctl.sv | 73 +++++++
 tb/tb_pipe_hazard_ctl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctl_if.sv
// Decode/branch-side signal bundle for the pipeline hazard controller.
// The master drives decode and branch status; the slave returns stall/flush and its counters.
interface pipe_hazard_ctl_if #(
    parameter int unsigned REGNOBITS = 6,
    parameter int unsigned CNTBITS   = 16
);
    logic [REGNOBITS-1:0] rs_D;
    logic [REGNOBITS-1:0] rt_D;
    logic                 usesrs_D;
    logic                 usesrt_D;
    logic                 wrreg_D;
    logic [REGNOBITS-1:0] wregno_D;
    logic                 isnop_D;
    logic                 mispred_B;
    logic                 stall_F;
    logic                 flush_D;
    logic [CNTBITS-1:0]   stallcnt;
    logic [CNTBITS-1:0]   flushcnt;
    logic                 busy;

    modport master (
        output rs_D, rt_D, usesrs_D, usesrt_D, wrreg_D, wregno_D, isnop_D, mispred_B,
        input  stall_F, flush_D, stallcnt, flushcnt, busy
    );

    modport slave (
        input  rs_D, rt_D, usesrs_D, usesrt_D, wrreg_D, wregno_D, isnop_D, mispred_B,
        output stall_F, flush_D, stallcnt, flushcnt, busy
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Interlock controller: a shifting scoreboard of in-flight register writes.
// Stalls decode on RAW hazards, flushes decode on mispredict, and counts both events.
module pipe_hazard_ctl #(
    parameter int unsigned REGNOBITS = 6,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CNTBITS   = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctl_if.slave   bus
);

    logic [DEPTH-1:0]     r_valid;
    logic [REGNOBITS-1:0] r_regno [DEPTH];
    logic [CNTBITS-1:0]   r_stallcnt;
    logic [CNTBITS-1:0]   r_flushcnt;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;
    logic w_stall;
    logic w_load_valid;

    // Match decode sources against every valid in-flight destination (r0 included)
    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_valid[i] && (r_regno[i] == bus.rs_D)) w_rs_hit = 1'b1;
            if (r_valid[i] && (r_regno[i] == bus.rt_D)) w_rt_hit = 1'b1;
        end
    end

    // isnop_D gates first so garbage source fields never reach the stall output
    assign w_hazard     = !bus.isnop_D && ((bus.usesrs_D && w_rs_hit) || (bus.usesrt_D && w_rt_hit));
    assign w_stall      = w_hazard && !bus.mispred_B;
    assign w_load_valid = !bus.mispred_B && !w_stall && !bus.isnop_D && bus.wrreg_D;

    // Scoreboard shifts every edge; the last entry falls off as committed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_regno[i] <= '0;
        end else begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1];
                r_regno[i] <= r_regno[i-1];
            end
            r_valid[0] <= w_load_valid;
            r_regno[0] <= bus.wregno_D;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallcnt <= '0;
            r_flushcnt <= '0;
        end else begin
            if (w_stall && (r_stallcnt != '1))
                r_stallcnt <= r_stallcnt + CNTBITS'(1);
            if (bus.mispred_B && (r_flushcnt != '1))
                r_flushcnt <= r_flushcnt + CNTBITS'(1);
        end
    end

    assign bus.stall_F  = w_stall;
    assign bus.flush_D  = bus.mispred_B;
    assign bus.stallcnt = r_stallcnt;
    assign bus.flushcnt = r_flushcnt;
    assign bus.busy     = |r_valid;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl with hand-computed expectations (narrow counters
// so saturation is reachable in a short run).
module tb_pipe_hazard_ctl;

    localparam int unsigned RB = 6;
    localparam int unsigned DP = 2;
    localparam int unsigned CB = 4;
    localparam logic [31:0] CNT_MAX = 32'((1 << CB) - 1);

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_hazard_ctl_if #(.REGNOBITS(RB), .CNTBITS(CB)) bus ();

    pipe_hazard_ctl #(.REGNOBITS(RB), .DEPTH(DP), .CNTBITS(CB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [RB-1:0] rs, input logic urs, input logic [RB-1:0] rt,
                         input logic urt, input logic wr, input logic [RB-1:0] wno,
                         input logic nop, input logic mis);
        bus.rs_D      = rs;
        bus.usesrs_D  = urs;
        bus.rt_D      = rt;
        bus.usesrt_D  = urt;
        bus.wrreg_D   = wr;
        bus.wregno_D  = wno;
        bus.isnop_D   = nop;
        bus.mispred_B = mis;
    endtask

    task automatic nop_in();
        drive('0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop_in();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        reset = 1'b1;
        nop_in();

        // Held reset: empty scoreboard, zero counters, nop never stalls
        step();
        drive('1, 1'b1, '1, 1'b1, 1'b1, 6'd1, 1'b1, 1'b0);
        mid();
        check("rst_stall", 32'(bus.stall_F), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_stallcnt", 32'(bus.stallcnt), 0);
        check("rst_flushcnt", 32'(bus.flushcnt), 0);
        check("rst_flush", 32'(bus.flush_D), 0);
        do_reset();

        // Back-to-back dependency on r5
        drive('0, 1'b0, '0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0);
        mid(); check("b2b_c0_stall", 32'(bus.stall_F), 0);
        step();
        drive(6'd5, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        mid(); check("b2b_c1_stall", 32'(bus.stall_F), 1);
        check("b2b_c1_busy", 32'(bus.busy), 1);
        step();
        mid(); check("b2b_c2_stall", 32'(bus.stall_F), 1);
        step();
        mid(); check("b2b_c3_stall", 32'(bus.stall_F), 0);
        check("b2b_stallcnt", 32'(bus.stallcnt), 2);
        check("b2b_c3_busy", 32'(bus.busy), 0);
        step();

        // Distance-2 dependency on r7 through rt
        do_reset();
        drive('0, 1'b0, '0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0);
        mid(); check("d2_c0_stall", 32'(bus.stall_F), 0);
        step();
        drive(6'd2, 1'b1, '0, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0);
        mid(); check("d2_c1_stall", 32'(bus.stall_F), 0);
        step();
        drive('0, 1'b0, 6'd7, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        mid(); check("d2_c2_stall", 32'(bus.stall_F), 1);
        step();
        mid(); check("d2_c3_stall", 32'(bus.stall_F), 0);
        check("d2_stallcnt", 32'(bus.stallcnt), 1);
        step();

        // Mispredict beats a hazard in the same cycle
        do_reset();
        drive('0, 1'b0, '0, 1'b0, 1'b1, 6'd9, 1'b0, 1'b0);
        step();
        drive('0, 1'b0, 6'd9, 1'b1, 1'b1, 6'd4, 1'b0, 1'b1);
        mid(); check("mp_stall", 32'(bus.stall_F), 0);
        check("mp_flush", 32'(bus.flush_D), 1);
        step();
        nop_in();
        mid(); check("mp_flushcnt", 32'(bus.flushcnt), 1);
        check("mp_stallcnt", 32'(bus.stallcnt), 0);
        check("mp_flush_off", 32'(bus.flush_D), 0);
        check("mp_busy_c2", 32'(bus.busy), 1);
        step();
        mid(); check("mp_e0_bubble", 32'(bus.busy), 0);
        step();

        // Unused source and nop decode never stall; nop pushes bubbles
        do_reset();
        drive('0, 1'b0, '0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0);
        step();
        drive(6'd3, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1 check("nop_unused_rs", 32'(bus.stall_F), 0);
        drive(6'd3, 1'b1, 6'd3, 1'b1, 1'b1, 6'd3, 1'b1, 1'b0);
        #1 check("nop_isnop", 32'(bus.stall_F), 0);
        drive('x, 1'b1, 'x, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        mid(); check("nop_xfree", 32'(bus.stall_F), 0);
        check("nop_busy_c1", 32'(bus.busy), 1);
        step();
        nop_in();
        mid(); check("nop_busy_c2", 32'(bus.busy), 1);
        step();
        mid(); check("nop_busy_c3", 32'(bus.busy), 0);
        step();

        // Flush counter saturation
        do_reset();
        drive('0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) step();
        mid(); check("flush_sat", 32'(bus.flushcnt), CNT_MAX);

        // Long-lived self-dependent r1 reader/writer: stalls 2 of every 3 cycles
        do_reset();
        drive(6'd1, 1'b1, '0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0);
        exp_cnt = 0;
        for (int k = 0; k < 31; k++) begin
            mid();
            check("sat_stall", 32'(bus.stall_F), ((k % 3) != 0) ? 32'd1 : 32'd0);
            check("sat_cnt", 32'(bus.stallcnt), 32'(exp_cnt));
            if (((k % 3) != 0) && (exp_cnt < int'(CNT_MAX))) exp_cnt++;
            step();
        end
        mid();
        check("sat_final", 32'(bus.stallcnt), CNT_MAX);
        check("sat_mid_stall", 32'(bus.stall_F), 1);

        // Asynchronous reset mid-stall, then held across an edge with live decode
        #1 reset = 1'b1;
        #1;
        check("arst_stallcnt", 32'(bus.stallcnt), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_stall", 32'(bus.stall_F), 0);
        bus.mispred_B = 1'b1;
        step();
        check("arst_hold_busy", 32'(bus.busy), 0);
        check("arst_hold_flushcnt", 32'(bus.flushcnt), 0);
        bus.mispred_B = 1'b0;
        reset = 1'b0;
        mid(); check("arst_after_stall", 32'(bus.stall_F), 0);
        step();
        mid(); check("arst_after_c1_stall", 32'(bus.stall_F), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
